// File: rtl/spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_arbiter
//  Purpose  : Shares one single-port RAM between an SPI-slave command stream
//             and a host port. The SPI side sets write/read addresses and
//             posts one data access at a time. Contention is resolved
//             round-robin. Read data returns two cycles after the RAM strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH+1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  spi_ovf
);

    // FSM encoding
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_RD_WAIT = 2'd2;

    // SPI command field values
    localparam logic [1:0] c_CMD_WADDR = 2'b00;
    localparam logic [1:0] c_CMD_RADDR = 2'b10;

    // Identity of the requester served last
    localparam logic c_SRV_HOST = 1'b0;
    localparam logic c_SRV_SPI  = 1'b1;

    logic [1:0]            r_state;
    logic                  r_rx_valid_q;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_spi_pend;
    logic                  r_spi_we;
    logic [ADDR_WIDTH-1:0] r_spi_addr;
    logic [DATA_WIDTH-1:0] r_spi_wdata;
    logic                  r_spi_ovf;
    logic                  r_last_srv;
    logic                  r_win_spi;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_host_gnt;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic                  r_host_rvalid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;

    logic [1:0]            w_cmd;
    logic [ADDR_WIDTH-1:0] w_payload;
    logic [DATA_WIDTH-1:0] w_payload_data;
    logic                  w_accept;
    logic                  w_data_cmd;
    logic                  w_spi_win;
    logic                  w_spi_free;

    assign w_cmd     = rx_data[ADDR_WIDTH+1:ADDR_WIDTH];
    assign w_payload = rx_data[ADDR_WIDTH-1:0];

    // Write data comes from the payload field; fit it to the RAM data width.
    generate
        if (DATA_WIDTH <= ADDR_WIDTH) begin : g_pl_trunc
            assign w_payload_data = w_payload[DATA_WIDTH-1:0];
        end else begin : g_pl_ext
            assign w_payload_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_payload};
        end
    endgenerate

    // Only a low-to-high transition of rx_valid delivers a word.
    assign w_accept   = rx_valid & ~r_rx_valid_q;
    // Commands 01 and 11 are the ones that need a RAM access.
    assign w_data_cmd = w_accept & w_cmd[0];
    // SPI wins when it is alone, or on a tie when the host went last.
    assign w_spi_win  = r_spi_pend & (~host_req | (r_last_srv == c_SRV_HOST));
    // The pending SPI slot is released while its own access is on the RAM.
    assign w_spi_free = (r_state == c_ISSUE) & r_win_spi;

    // Command decode, pending-slot bookkeeping, arbitration and access FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_rx_valid_q  <= 1'b0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_spi_pend    <= 1'b0;
            r_spi_we      <= 1'b0;
            r_spi_addr    <= '0;
            r_spi_wdata   <= '0;
            r_spi_ovf     <= 1'b0;
            r_last_srv    <= c_SRV_HOST;
            r_win_spi     <= 1'b0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_host_gnt    <= 1'b0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
        end else begin
            r_rx_valid_q  <= rx_valid;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;

            if (w_accept) begin
                r_tx_valid <= 1'b0;
                case (w_cmd)
                    c_CMD_WADDR: r_wr_addr <= w_payload;
                    c_CMD_RADDR: r_rd_addr <= w_payload;
                    default:     ;
                endcase
            end

            // A data command fills the slot if it is empty or being freed
            // this very cycle; otherwise it is lost and flagged.
            if (w_data_cmd) begin
                if (!r_spi_pend || w_spi_free) begin
                    r_spi_pend  <= 1'b1;
                    r_spi_we    <= ~w_cmd[1];
                    r_spi_addr  <= w_cmd[1] ? r_rd_addr : r_wr_addr;
                    r_spi_wdata <= w_payload_data;
                end else begin
                    r_spi_ovf <= 1'b1;
                end
            end else if (w_spi_free) begin
                r_spi_pend <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (r_spi_pend || host_req) begin
                        r_state    <= c_ISSUE;
                        r_ram_en   <= 1'b1;
                        r_win_spi  <= w_spi_win;
                        r_last_srv <= w_spi_win ? c_SRV_SPI : c_SRV_HOST;
                        r_host_gnt <= ~w_spi_win;
                        if (w_spi_win) begin
                            r_ram_we    <= r_spi_we;
                            r_ram_addr  <= r_spi_addr;
                            r_ram_wdata <= r_spi_wdata;
                        end else begin
                            r_ram_we    <= host_we;
                            r_ram_addr  <= host_addr;
                            r_ram_wdata <= host_wdata;
                        end
                    end
                end
                c_ISSUE: begin
                    r_ram_en <= 1'b0;
                    r_state  <= r_ram_we ? c_IDLE : c_RD_WAIT;
                end
                c_RD_WAIT: begin
                    r_state <= c_IDLE;
                    if (r_win_spi) begin
                        r_tx_data  <= ram_rdata;
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_host_rdata  <= ram_rdata;
                        r_host_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_ram_en <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign host_gnt    = r_host_gnt;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;
    assign ram_en      = r_ram_en;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign spi_ovf     = r_spi_ovf;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_ram_arbiter
//  Purpose  : Self-checking bench for spi_ram_arbiter: random SPI/host
//             transactions against a memory-level reference model, plus
//             directed arbitration, overflow and reset scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          spi_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_rvalid = 0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;
    acc_t acc_q[$];

    // Environment RAM and the reference model's view of its contents
    logic [DW-1:0] r_mem   [0:255] = '{default: '0};
    logic [DW-1:0] ref_mem [0:255] = '{default: '0};

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .spi_ovf    (spi_ovf)
    );

    // Synchronous RAM: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) r_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= r_mem[ram_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Log every RAM access and count host read-data pulses
    always @(negedge clk) begin
        if (ram_en) acc_q.push_back({ram_we, ram_addr, ram_wdata});
        if (host_rvalid) n_rvalid <= n_rvalid + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_send(input logic [AW+1:0] w, input int hold);
        rx_data  = w;
        rx_valid = 1'b1;
        step(hold);
        rx_valid = 1'b0;
        step(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".tx_valid"},    tx_valid,    0);
        chk({tag, ".tx_data"},     tx_data,     0);
        chk({tag, ".host_gnt"},    host_gnt,    0);
        chk({tag, ".host_rvalid"}, host_rvalid, 0);
        chk({tag, ".host_rdata"},  host_rdata,  0);
        chk({tag, ".ram_en"},      ram_en,      0);
        chk({tag, ".ram_we"},      ram_we,      0);
        chk({tag, ".ram_addr"},    ram_addr,    0);
        chk({tag, ".ram_wdata"},   ram_wdata,   0);
        chk({tag, ".spi_ovf"},     spi_ovf,     0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        step(3);
        chk_reset_outputs(tag);
        rst = 1'b0;
        step(1);
    endtask

    // Host access from an idle arbiter: grant next cycle, read data 3 cycles on
    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   t0;
        int   n0;
        logic got;
        n0 = acc_q.size();
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        t0 = cyc; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (host_gnt) got = 1'b1;
        end
        host_req = 1'b0;
        chk("host.gnt_seen", got, 1);
        chk("host.gnt_latency", cyc - t0, 1);
        if (we) begin
            ref_mem[a] = d;
            step(2);
            chk("host.wr_count", acc_q.size(), n0 + 1);
            chk("host.wr_access", acc_q[acc_q.size()-1], {1'b1, a, d});
        end else begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                step(1);
                if (host_rvalid) got = 1'b1;
            end
            chk("host.rvalid_seen", got, 1);
            chk("host.rd_latency", cyc - t0, 3);
            chk("host.rdata", host_rdata, ref_mem[a]);
            step(1);
            chk("host.rvalid_pulse", host_rvalid, 0);
        end
    endtask

    task automatic spi_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n0;
        n0 = acc_q.size();
        spi_send({2'b00, a}, $urandom_range(1, 4));
        spi_send({2'b01, d}, $urandom_range(1, 4));
        step(4);
        ref_mem[a] = d;
        chk("spi.wr_count", acc_q.size(), n0 + 1);
        chk("spi.wr_access", acc_q[acc_q.size()-1], {1'b1, a, d});
    endtask

    task automatic spi_read(input logic [AW-1:0] a);
        int   t0;
        int   hold;
        logic got;
        logic [DW-1:0] first;
        spi_send({2'b10, a}, $urandom_range(1, 4));
        chk("spi.tx_cleared", tx_valid, 0);
        hold = $urandom_range(1, 6);
        rx_data = {2'b11, 8'($urandom)};
        rx_valid = 1'b1;
        t0 = cyc; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (cyc - t0 >= hold) rx_valid = 1'b0;
            if (tx_valid) got = 1'b1;
        end
        rx_valid = 1'b0;
        chk("spi.tx_seen", got, 1);
        chk("spi.rd_latency", cyc - t0, 4);
        chk("spi.tx_data", tx_data, ref_mem[a]);
        first = tx_data;
        step(3);
        chk("spi.tx_hold_valid", tx_valid, 1);
        chk("spi.tx_hold_data", tx_data, first);
    endtask

    initial begin
        int            n0;
        int            nr;
        int            spi_cnt;
        int            hcnt;
        logic          got;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        do_reset("reset0");

        // Random single-requester transactions against the memory model
        for (int k = 0; k < 30; k++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: spi_write(a, d);
                1: spi_read(a);
                2: host_op(1'b1, a, d);
                default: host_op(1'b0, a, d);
            endcase
        end
        chk("rand.no_ovf", spi_ovf, 0);

        // SPI write of 0xA7 to 0x05 with rx_valid held for several cycles
        do_reset("reset1");
        n0 = acc_q.size();
        spi_send(10'h005, 4);
        spi_send(10'h1A7, 4);
        step(3);
        ref_mem[8'h05] = 8'hA7;
        chk("w05.count", acc_q.size(), n0 + 1);
        chk("w05.access", acc_q[n0], {1'b1, 8'h05, 8'hA7});
        chk("w05.no_ovf", spi_ovf, 0);

        // SPI read back of 0x05 and tx hold until the next word
        spi_send(10'h205, 4);
        spi_send(10'h300, 4);
        step(1);
        chk("r05.tx_valid", tx_valid, 1);
        chk("r05.tx_data", tx_data, 8'hA7);
        step(6);
        chk("r05.held_valid", tx_valid, 1);
        chk("r05.held_data", tx_data, 8'hA7);
        spi_send(10'h005, 1);
        chk("r05.cleared", tx_valid, 0);

        // Round-robin: host write busies the RAM, then host read and SPI
        // write are raised together and kept pending
        do_reset("reset2");
        spi_send(10'h003, 1);
        n0 = acc_q.size();
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h55;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (host_gnt) got = 1'b1;
        end
        chk("rr.pre_gnt", got, 1);
        ref_mem[8'h40] = 8'h55;
        host_we = 1'b0; host_addr = 8'h10;
        rx_data = {2'b01, 8'h00};
        rx_valid = 1'b1;
        spi_cnt = 1; hcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (rx_valid) rx_valid = 1'b0;
            if (ram_en && ram_we && spi_cnt < 3) begin
                rx_data = {2'b01, 8'(spi_cnt)};
                rx_valid = 1'b1;
                spi_cnt++;
            end
            if (host_gnt) begin
                hcnt++;
                if (hcnt >= 3) host_req = 1'b0;
            end
        end
        chk("rr.count", acc_q.size(), n0 + 7);
        for (int k = 0; k < 6; k++) begin
            if (n0 + 1 + k < acc_q.size()) begin
                chk($sformatf("rr.order%0d", k), acc_q[n0+1+k].we, (k % 2 == 0));
                if (k % 2 == 0)
                    chk($sformatf("rr.spi%0d", k), acc_q[n0+1+k], {1'b1, 8'h03, 8'(k/2)});
                else
                    chk($sformatf("rr.host%0d", k), acc_q[n0+1+k].addr, 8'h10);
            end
        end
        chk("rr.no_ovf", spi_ovf, 0);
        ref_mem[8'h03] = 8'h02;

        // Two SPI writes while the host read occupies the RAM
        do_reset("reset3");
        spi_send(10'h020, 1);
        n0 = acc_q.size();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h11;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (host_gnt) got = 1'b1;
        end
        chk("ovf.gnt", got, 1);
        host_req = 1'b0;
        rx_data = 10'h15A; rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        step(1);
        rx_data = 10'h16B; rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        step(6);
        ref_mem[8'h20] = 8'h5A;
        chk("ovf.flag", spi_ovf, 1);
        chk("ovf.count", acc_q.size(), n0 + 2);
        chk("ovf.host", acc_q[n0], {1'b0, 8'h11, 8'h00} | {17'b0, acc_q[n0].data});
        chk("ovf.write", acc_q[n0+1], {1'b1, 8'h20, 8'h5A});

        // Reset during the read-wait of a host read
        do_reset("reset4");
        nr = n_rvalid;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (host_gnt) got = 1'b1;
        end
        chk("rstmid.gnt", got, 1);
        host_req = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk_reset_outputs("rstmid");
        step(2);
        rst = 1'b0;
        step(3);
        chk("rstmid.no_rvalid", n_rvalid, nr);
        host_op(1'b1, 8'h13, 8'h3C);
        host_op(1'b0, 8'h13, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
